fabosc_clken_gen: RTL and testbench

Parametrised multi-channel clock-enable generator driven by the fabric RC oscillator clock (RCOSC_25_50MHZ_O2F, 50 MHz). It replaces ad-hoc per-module dividers with NUM_CH independent, runtime-programmable strobe generators. Divisor changes are glitch-free, and all channels share a common phase-alignment restart. Downstream FSM ADC/DAC sequencers qualify their logic with the tick outputs instead of using derived clocks.

---
 rtl/fabosc_clken_gen_pkg.sv | 21 ++
 rtl/fabosc_clken_gen_if.sv | 40 ++++
 rtl/fabosc_clken_gen_ch.sv | 164 ++++++++++++++++
 rtl/fabosc_clken_gen.sv | 46 ++++
 tb/tb_fabosc_clken_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fabosc_clken_gen_pkg.sv
// fabosc_clken_gen: shared types, limits and helpers.
// Divisor defaults, channel limit, channel states, eff_div().
package fabosc_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int NUM_CH_MAX = 16;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_RUN_PEND
  } ch_state_e;

  // A programmed divisor of 0 behaves as 1.
  function automatic logic [31:0] eff_div(
    input logic [31:0] d
  );
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/fabosc_clken_gen_if.sv
// fabosc_clken_gen: control/strobe bundle between host and generator.
// div_i/load_i/en_i/sync_i in, tick_o/pend_o (sq_o if FABOSC_CLKEN_SQWAVE_EN) out.
interface fabosc_clken_gen_if
  import fabosc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DIV_W_DEF
);

  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       load_i;
  logic [NUM_CH-1:0]       en_i;
  logic                    sync_i;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       pend_o;
`ifdef FABOSC_CLKEN_SQWAVE_EN
  logic [NUM_CH-1:0]       sq_o;

  modport master (
    output div_i, load_i, en_i, sync_i,
    input  tick_o, pend_o, sq_o
  );

  modport slave (
    input  div_i, load_i, en_i, sync_i,
    output tick_o, pend_o, sq_o
  );
`else
  modport master (
    output div_i, load_i, en_i, sync_i,
    input  tick_o, pend_o
  );

  modport slave (
    input  div_i, load_i, en_i, sync_i,
    output tick_o, pend_o
  );
`endif

endinterface

// File: rtl/fabosc_clken_gen_ch.sv
// fabosc_clken_ch: one programmable clock-enable strobe channel.
// In: div_i, load_i, en_i, sync_i. Out: tick_o, pend_o, sq_o (FABOSC_CLKEN_SQWAVE_EN).
module fabosc_clken_ch
  import fabosc_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             sync_i,
`ifdef FABOSC_CLKEN_SQWAVE_EN
  output logic             sq_o,
`endif
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] RST_CNT =
    DIV_W'(eff_div(32'(DIV_RST)) - 32'd1);

  function automatic logic [DIV_W-1:0] reload(
    input logic [DIV_W-1:0] d
  );
    logic [31:0] e;
    e = eff_div(32'(d));
    return DIV_W'(e - 32'd1);
  endfunction

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
`ifdef FABOSC_CLKEN_SQWAVE_EN
  logic             sq_q, sq_d;
`endif

  logic             run;
  logic             term;
  logic             src_pend;
  logic [DIV_W-1:0] src_div;
  logic             do_sync;
  logic             do_term;
  logic             do_hold;
  logic             do_cnt;

  // The first enabled edge out of IDLE only holds, so
  // a fresh enable yields a full D-cycle first period.
  assign run  = en_i && (state_q != CH_IDLE);
  assign term = run && (cnt_q == '0);

  // A load on an applying edge wins over the old pending value.
  assign src_pend = load_i | pend_q;
  assign src_div  = load_i ? div_i : pdiv_q;

  assign do_sync = sync_i;
  assign do_term = term & ~sync_i;
  assign do_hold = ~run & ~sync_i;
  assign do_cnt  = run & ~term & ~sync_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
`ifdef FABOSC_CLKEN_SQWAVE_EN
    sq_d    = sq_q;
`endif
    unique case (1'b1)
      do_sync: begin
        if (src_pend) begin
          act_d  = src_div;
          pdiv_d = src_div;
        end
        pend_d = 1'b0;
        cnt_d  = reload(act_d);
`ifdef FABOSC_CLKEN_SQWAVE_EN
        sq_d   = 1'b0;
`endif
      end
      do_term: begin
        if (src_pend) begin
          act_d  = src_div;
          pdiv_d = src_div;
        end
        pend_d = 1'b0;
        cnt_d  = reload(act_d);
        tick_d = 1'b1;
`ifdef FABOSC_CLKEN_SQWAVE_EN
        sq_d   = ~sq_q;
`endif
      end
      do_hold: begin
        if (pend_q) begin
          act_d = pdiv_q;
        end
        pend_d = 1'b0;
        if (load_i) begin
          pdiv_d = div_i;
          pend_d = 1'b1;
        end
        cnt_d = reload(act_d);
      end
      do_cnt: begin
        cnt_d = cnt_q - DIV_W'(1);
        if (load_i) begin
          pdiv_d = div_i;
          pend_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (!en_i) begin
      state_d = CH_IDLE;
    end else if (pend_d) begin
      state_d = CH_RUN_PEND;
    end else begin
      state_d = CH_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= RST_CNT;
      act_q   <= RST_DIV;
      pdiv_q  <= RST_DIV;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
    end
  end

`ifdef FABOSC_CLKEN_SQWAVE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_o = sq_q;
`endif

  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/fabosc_clken_gen.sv
// fabosc_clken_gen: NUM_CH runtime-programmable clock-enable strobes.
// CLK, RESETN (async low), bus (slave). Optional sq_o: FABOSC_CLKEN_SQWAVE_EN.
module fabosc_clken_gen
  import fabosc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 50
) (
  input  logic               CLK,
  input  logic               RESETN,
  fabosc_clken_gen_if.slave  bus
);

  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] pend_w;
`ifdef FABOSC_CLKEN_SQWAVE_EN
  logic [NUM_CH-1:0] sq_w;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fabosc_clken_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk    (CLK),
      .rst_n  (RESETN),
      .div_i  (bus.div_i[c*DIV_W +: DIV_W]),
      .load_i (bus.load_i[c]),
      .en_i   (bus.en_i[c]),
      .sync_i (bus.sync_i),
`ifdef FABOSC_CLKEN_SQWAVE_EN
      .sq_o   (sq_w[c]),
`endif
      .tick_o (tick_w[c]),
      .pend_o (pend_w[c])
    );
  end

  assign bus.tick_o = tick_w;
  assign bus.pend_o = pend_w;
`ifdef FABOSC_CLKEN_SQWAVE_EN
  assign bus.sq_o   = sq_w;
`endif

endmodule

// File: tb/tb_fabosc_clken_gen.sv
// tb_fabosc_clken_gen: directed self-checking bench for fabosc_clken_gen.
// Drives the bus via the interface, checks tick/pend timing.
module tb_fabosc_clken_gen;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fabosc_clken_gen_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

  fabosc_clken_gen #(
    .NUM_CH  (NCH),
    .DIV_W   (DW),
    .DIV_RST (50)
  ) dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [NCH-1:0] tick_seen;
  logic [NCH-1:0] pend_seen;
  int             first_t [NCH];
  int             cnt_t   [NCH];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int ch, input int v);
    bus.div_i[ch*DW +: DW] = DW'(v);
  endtask

  // Steps until tick_o[ch]; n = steps taken, maxc+1 on timeout.
  task automatic wait_tick(
    input  int ch,
    input  int maxc,
    output int n
  );
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < maxc) begin
      step();
      n++;
      tick_seen |= bus.tick_o;
      pend_seen |= bus.pend_o;
      if (bus.tick_o[ch]) found = 1'b1;
    end
    if (!found) n = maxc + 1;
  endtask

  task automatic run_watch(input int ncyc);
    pend_seen = '0;
    for (int c = 0; c < NCH; c++) begin
      first_t[c] = 0;
      cnt_t[c]   = 0;
    end
    for (int i = 1; i <= ncyc; i++) begin
      step();
      pend_seen |= bus.pend_o;
      for (int c = 0; c < NCH; c++) begin
        if (bus.tick_o[c]) begin
          cnt_t[c]++;
          if (first_t[c] == 0) first_t[c] = i;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.div_i  = '0;
    bus.load_i = '0;
    bus.en_i   = '0;
    bus.sync_i = 1'b0;
    tick_seen  = '0;
    pend_seen  = '0;

    // Reset state
    repeat (3) step();
    check("rst_tick", 32'(bus.tick_o), 0);
    check("rst_pend", 32'(bus.pend_o), 0);
`ifdef FABOSC_CLKEN_SQWAVE_EN
    check("rst_sq", 32'(bus.sq_o), 0);
`endif

    // Default divisor 50 on channel 0
    rst_n = 1'b1;
    bus.en_i = 4'b0001;
    wait_tick(0, 60, n);
    check("first_tick_d50", n, 51);
    wait_tick(0, 60, n);
    check("period_d50", n, 50);
    check("others_silent", 32'(tick_seen & 4'b1110), 0);
    check("pend_idle", 32'(pend_seen), 0);

    // Divisor 10 loaded while disabled
    bus.en_i = 4'b0000;
    step();
    bus.load_i = 4'b0001;
    set_div(0, 10);
    step();
    bus.load_i = 4'b0000;
    check("pend_load_idle", 32'(bus.pend_o[0]), 1);
    step();
    check("pend_applied_idle", 32'(bus.pend_o[0]), 0);
    bus.en_i = 4'b0001;
    wait_tick(0, 20, n);
    check("first_tick_d10", n, 11);

    // Mid-period load of 3
    repeat (4) step();
    bus.load_i = 4'b0001;
    set_div(0, 3);
    step();
    bus.load_i = 4'b0000;
    check("pend_mid_period", 32'(bus.pend_o[0]), 1);
    wait_tick(0, 20, n);
    check("tick_after_load", n, 5);
    check("pend_clr_at_tick", 32'(bus.pend_o[0]), 0);
    wait_tick(0, 20, n);
    check("period_d3_a", n, 3);
    wait_tick(0, 20, n);
    check("period_d3_b", n, 3);

    // Divisor 0 on channel 1 while disabled
    bus.load_i = 4'b0010;
    set_div(1, 0);
    step();
    bus.load_i = 4'b0000;
    step();
    check("pend1_applied", 32'(bus.pend_o[1]), 0);
    bus.en_i = 4'b0011;
    wait_tick(1, 10, n);
    check("first_tick_d0", n, 2);
    run_watch(6);
    check("d0_every_cycle", cnt_t[1], 6);
    check("d0_no_pend", 32'(pend_seen[1]), 0);

    // Divisors 5 and 7, then sync on a ch0 terminal edge
    bus.en_i = 4'b0000;
    bus.load_i = 4'b0011;
    set_div(0, 5);
    set_div(1, 7);
    step();
    bus.load_i = 4'b0000;
    step();
    check("pend_57_applied", 32'(bus.pend_o[1:0]), 0);
    bus.en_i = 4'b0011;
    wait_tick(0, 20, n);
    check("first_tick_d5", n, 6);
    repeat (4) step();
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    check("sync_kills_tick", 32'(bus.tick_o[1:0]), 0);
`ifdef FABOSC_CLKEN_SQWAVE_EN
    check("sync_clears_sq", 32'(bus.sq_o[1:0]), 0);
`endif
    run_watch(10);
    check("sync_ch0_d5", first_t[0], 5);
    check("sync_ch1_d7", first_t[1], 7);

    // Load and sync on the same edge
    bus.load_i = 4'b0001;
    set_div(0, 8);
    bus.sync_i = 1'b1;
    step();
    bus.load_i = 4'b0000;
    bus.sync_i = 1'b0;
    check("ld_sync_pend", 32'(bus.pend_o[0]), 0);
    run_watch(12);
    check("ld_sync_ch0_d8", first_t[0], 8);
    check("ld_sync_ch1_d7", first_t[1], 7);
    check("ld_sync_no_pend", 32'(pend_seen[1:0]), 0);

    // Reset in the middle of a period
    bus.load_i = 4'b0001;
    set_div(0, 20);
    step();
    bus.load_i = 4'b0000;
    check("pend_before_rst", 32'(bus.pend_o[0]), 1);
    wait_tick(1, 20, n);
    check("ch1_tick_before_rst", n, 1);
    #3;
    check("pre_rst_tick1", 32'(bus.tick_o[1]), 1);
    check("pre_rst_pend0", 32'(bus.pend_o[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_tick", 32'(bus.tick_o), 0);
    check("async_rst_pend", 32'(bus.pend_o), 0);
    bus.en_i = 4'b0001;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_tick(0, 60, n);
    check("post_rst_first_tick", n, 51);
`ifdef FABOSC_CLKEN_SQWAVE_EN
    check("sq_after_tick1", 32'(bus.sq_o[0]), 1);
`endif
    wait_tick(0, 60, n);
    check("post_rst_period", n, 50);
`ifdef FABOSC_CLKEN_SQWAVE_EN
    check("sq_after_tick2", 32'(bus.sq_o[0]), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
